ps2_rx_buf: RTL
===============

Name: ps2_rx_buf

Overview:
- Parametrised PS/2 device-to-host receiver with an input glitch filter, a frame-timeout watchdog, per-frame parity/stop checking, and a first-word-fall-through (FWFT) receive FIFO.
- Sits between the PS/2 pins and the keyboard/mouse decoder.
- Lets the consumer drain scan codes at its own pace, without losing bytes to back-to-back frames.
- Unlike the single-byte receiver, a stalled or corrupted frame can never hang the block.

Parameters:
- SYNC_STAGES, 3, synchroniser flops on ps2_clk and ps2_data; minimum 2.
- FILT_LEN, 4, consecutive identical synchronised samples needed before the filtered ps2_clk changes level; minimum 1.
- TIMEOUT_CYC, 50000, clk_sys cycles without a filtered falling edge before a partial frame is aborted (1 ms at 50 MHz).
- FIFO_DEPTH, 16, receive FIFO entries; must be a power of 2, minimum 2.
- DROP_BAD, 1, when 1, frames with a parity or stop error are not written to the FIFO; when 0, they are written with rd_perr=1.

Ports:
- clk_sys  in  1  system clock, 50 MHz.
- rst_n  in  1  reset; asynchronous, active-low.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous to clk_sys.
- ps2_data  in  1  raw PS/2 data pin, asynchronous to clk_sys.
- rd_en  in  1  pop request; honoured only when rd_vld=1.
- rd_vld  out  1  FIFO non-empty; rd_data and rd_perr are valid.
- rd_data  out  8  head-of-FIFO byte.
- rd_perr  out  1  head byte had a parity or stop error; always 0 when DROP_BAD=1.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  current occupancy.
- overflow  out  1  sticky: a completed frame was lost because the FIFO was full.
- timeout_err  out  1  one-cycle pulse when a partial frame is aborted.
- frame_err_cnt  out  8  count of bad frames, saturating at 255.
- clr_err  in  1  synchronous clear of overflow and frame_err_cnt.

Behaviour:
- Reset values:
  - All outputs 0; FIFO empty; FSM in IDLE.
  - Filtered clock, data registers and synchroniser chains reset to 1 (bus idle level).
- Input path:
  - Both pins pass through SYNC_STAGES flops.
  - The filtered clock takes the synchronised value only after FILT_LEN consecutive equal samples.
  - strobe = filtered clock changed 1->0 this cycle.
  - At strobe, the synchronised data is sampled, delayed by the same number of stages as the clock path.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on strobe with data=0, go to DATA with bit_cnt=0. On strobe with data=1, stay in IDLE (spurious edge).
  - DATA: on each strobe, shift the bit into the shift register, LSB first. bit_cnt is 3 bits; at strobe with bit_cnt=7, go to PARITY.
  - PARITY: on strobe, capture the parity bit and go to STOP.
  - STOP: on strobe, capture the stop bit, evaluate the frame, and go to IDLE.
  - A back-to-back start bit is handled from IDLE on the next strobe.
- Frame evaluation:
  - good = (XOR of 8 data bits and parity == 1) and (stop == 1).
  - A bad frame increments frame_err_cnt, saturating at 255.
- Push rule:
  - Push when (good or DROP_BAD==0) and (not full or a pop occurs in the same cycle).
  - Write latency: written at the clock edge ending the STOP-strobe cycle N; rd_vld=1 and data visible in cycle N+1.
  - If a push is required, the FIFO is full and no same-cycle pop occurs: the byte is dropped, overflow is set, and FIFO contents are unchanged.
- Timeout:
  - Counter clears on every strobe and is held at 0 in IDLE.
  - In any other state, when the count reaches TIMEOUT_CYC-1: return to IDLE, discard the partial frame, pulse timeout_err for 1 cycle.
  - No push and no frame_err_cnt increment on timeout.
- FIFO:
  - FWFT; pop = rd_en & rd_vld.
  - rd_en while empty is ignored; fifo_count never underflows.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop: count unchanged; legal when full (pop frees the slot) and when count=1.
- clr_err:
  - Clears overflow and frame_err_cnt at the next edge.
  - If an increment or overflow event occurs in the same cycle, the clear wins.
  - Does not touch the FIFO or the FSM.
- Reset asserted mid-frame or with the FIFO non-empty: everything returns to reset values immediately. The partial frame and the buffered bytes are lost.

Test Plan:
- Single frame 0x1C, parity 0, stop 1, at 12.5 kHz PS/2 clock -> rd_vld=1, rd_data=0x1C, rd_perr=0, fifo_count=1; pulse rd_en -> rd_vld=0, count=0.
- Frames 0xF0 then 0x1C back to back, no pops -> count=2, head 0xF0, next 0x1C; rd_en held high -> two pops, then empty.
- 0x1C with parity 1, DROP_BAD=1 -> nothing pushed, frame_err_cnt=1; repeat with DROP_BAD=0 -> rd_data=0x1C, rd_perr=1.
- 2-cycle low glitch on ps2_clk mid-idle (FILT_LEN=4) -> no strobe, FSM stays IDLE; then valid frame 0x5A -> received correctly.
- Start plus 4 data bits, then silence for 50000 cycles -> one timeout_err pulse, FSM in IDLE; next frame 0x5A received intact.
- 17 good frames 0x01..0x11, no pops, DEPTH=16 -> count=16, overflow=1, head 0x01, 0x11 lost; clr_err -> overflow=0. Reset mid-frame -> all outputs 0.

Source files
------------

// File: rtl/ps2_rx_buf.sv
// ps2_rx_buf: PS/2 device-to-host receiver with a receive FIFO.
//
// The raw pins are synchronised and the clock is glitch-filtered. An 11-bit
// frame (start, 8 data LSB first, odd parity, stop) is shifted in on the
// falling edges of the filtered clock. Each completed frame is checked and
// pushed into a first-word-fall-through FIFO. A watchdog aborts a partial
// frame if the clock stalls, so the receiver always returns to IDLE.
//
// Ports:
//   clk_sys, rst_n      system clock; asynchronous active-low reset
//   ps2_clk, ps2_data   raw PS/2 pins (asynchronous to clk_sys)
//   rd_en               pop request, honoured only while rd_vld=1
//   rd_vld/rd_data/rd_perr  head of FIFO (FWFT), zero when empty
//   fifo_count          current FIFO occupancy
//   overflow            sticky: a completed frame was lost to a full FIFO
//   timeout_err         one-cycle pulse when a partial frame is aborted
//   frame_err_cnt       saturating count of parity/stop errors
//   clr_err             synchronous clear of overflow and frame_err_cnt
//
// Handshake: rd_data/rd_perr are valid whenever rd_vld=1; a pop happens on
// every clock edge where rd_en=1 and rd_vld=1, otherwise rd_en is ignored.
module ps2_rx_buf #(
    parameter int SYNC_STAGES = 3,
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 16,
    parameter int DROP_BAD    = 1
) (
    input  logic                              clk_sys,
    input  logic                              rst_n,
    input  logic                              ps2_clk,
    input  logic                              ps2_data,
    input  logic                              rd_en,
    output logic                              rd_vld,
    output logic [7:0]                        rd_data,
    output logic                              rd_perr,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              overflow,
    output logic                              timeout_err,
    output logic [7:0]                        frame_err_cnt,
    input  logic                              clr_err
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // ---------------- input path ----------------
    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic [FILT_LEN-1:0]    data_dly_q;
    logic [FW-1:0]          filt_cnt_q, filt_cnt_d;
    logic                   filt_clk_q, filt_clk_d, filt_prev_q;
    logic                   clk_s, data_s, strobe;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    // Data is delayed by FILT_LEN so it stays aligned with the filtered clock.
    assign data_s = data_dly_q[FILT_LEN-1];
    assign strobe = filt_prev_q & ~filt_clk_q;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            data_dly_q  <= '1;
        end else begin
            clk_sync_q[0]  <= ps2_clk;
            data_sync_q[0] <= ps2_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                clk_sync_q[i]  <= clk_sync_q[i-1];
                data_sync_q[i] <= data_sync_q[i-1];
            end
            data_dly_q[0] <= data_sync_q[SYNC_STAGES-1];
            for (int i = 1; i < FILT_LEN; i++) begin
                data_dly_q[i] <= data_dly_q[i-1];
            end
        end
    end

    // filt_cnt_q counts consecutive samples that disagree with the filtered
    // level; the level flips on the FILT_LEN-th such sample.
    always_comb begin
        filt_cnt_d = filt_cnt_q;
        filt_clk_d = filt_clk_q;
        if (clk_s == filt_clk_q) begin
            filt_cnt_d = '0;
        end else if (filt_cnt_q == FW'(FILT_LEN - 1)) begin
            filt_clk_d = clk_s;
            filt_cnt_d = '0;
        end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt_q  <= '0;
            filt_clk_q  <= 1'b1;
            filt_prev_q <= 1'b1;
        end else begin
            filt_cnt_q  <= filt_cnt_d;
            filt_clk_q  <= filt_clk_d;
            filt_prev_q <= filt_clk_q;
        end
    end

    // ---------------- frame FSM ----------------
    state_t         state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic [TW-1:0]  to_cnt_q, to_cnt_d;
    logic           timeout_d, frame_done, frame_good;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        to_cnt_d   = to_cnt_q;
        timeout_d  = 1'b0;
        frame_done = 1'b0;
        frame_good = 1'b0;

        // Watchdog: only runs mid-frame and restarts on every strobe.
        if (state_q == IDLE || strobe) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
            to_cnt_d  = '0;
            state_d   = IDLE;
            timeout_d = 1'b1;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        if (strobe) begin
            case (state_q)
                IDLE: begin
                    if (!data_s) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = data_s;
                    state_d = STOP;
                end
                STOP: begin
                    frame_done = 1'b1;
                    frame_good = (^{shift_q, par_q}) & data_s;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            to_cnt_q    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            to_cnt_q    <= to_cnt_d;
            timeout_err <= timeout_d;
        end
    end

    // ---------------- FIFO and error status ----------------
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push_req, push, pop, full, ovf_evt;
    logic          overflow_q;
    logic [7:0]    err_cnt_q;

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign rd_vld   = (count_q != '0);
    assign pop      = rd_en & rd_vld;
    assign push_req = frame_done & (frame_good | (DROP_BAD == 0));
    // A same-cycle pop frees the slot, so a full FIFO can still accept.
    assign push     = push_req & (~full | pop);
    assign ovf_evt  = push_req & full & ~pop;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (push) mem_q[wr_ptr_q] <= {(DROP_BAD == 0) & ~frame_good, shift_q};
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (clr_err) begin
                overflow_q <= 1'b0;
                err_cnt_q  <= '0;
            end else begin
                if (ovf_evt) overflow_q <= 1'b1;
                if (frame_done && !frame_good && err_cnt_q != 8'd255)
                    err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    // Head is gated so outputs read zero while the FIFO is empty.
    assign rd_data       = rd_vld ? mem_q[rd_ptr_q][7:0] : 8'h00;
    assign rd_perr       = rd_vld ? mem_q[rd_ptr_q][8]   : 1'b0;
    assign fifo_count    = count_q;
    assign overflow      = overflow_q;
    assign frame_err_cnt = err_cnt_q;

endmodule
